// File: rtl/xgmii_frame_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xgmii_frame_monitor                                                        |
// | Passive 64-bit XGMII receive checker: frame length, good/bad, counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xgmii_frame_monitor #(
   parameter int MIN_LEN = 71,
   parameter int MAX_LEN = 1525
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic [63:0] xge_rxd_i,
   input  logic [7:0]  xge_rxc_i,
   output logic        frame_done_o,
   output logic        frame_good_o,
   output logic [15:0] last_len_o,
   output logic [31:0] good_cnt_o,
   output logic [31:0] bad_cnt_o,
   output logic [15:0] proto_err_cnt_o
);

   localparam logic [7:0]  C_CH_S   = 8'hFB;
   localparam logic [7:0]  C_CH_T   = 8'hFD;
   localparam logic [15:0] C_MIN    = MIN_LEN[15:0];
   localparam logic [15:0] C_MAX    = MAX_LEN[15:0];
   localparam logic [15:0] C_SAT    = 16'hFFFF;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_IN_FRAME = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_len;
   logic        r_bad;

   logic [7:0]  w_is_t;
   logic        w_s0;
   logic        w_s4;
   logic        w_t_any;
   logic        w_t_lo;
   logic        w_t_hi;
   logic [2:0]  w_t_lane;
   logic [7:0]  w_below_t;

   logic [15:0] w_len_nxt;
   logic        w_bad_nxt;
   logic        w_close;
   logic [15:0] w_close_len;
   logic        w_close_bad;
   logic        w_good;
   logic        w_proto;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'd0, b};
      return s[16] ? C_SAT : s[15:0];
   endfunction

   for (genvar g = 0; g < 8; g++) begin : g_lane
      assign w_is_t[g] = xge_rxc_i[g] && (xge_rxd_i[8*g +: 8] == C_CH_T);
   end

   assign w_s0    = xge_rxc_i[0] && (xge_rxd_i[7:0]   == C_CH_S);
   assign w_s4    = xge_rxc_i[4] && (xge_rxd_i[39:32] == C_CH_S);
   assign w_t_any = |w_is_t;
   assign w_t_lo  = |w_is_t[3:0];
   assign w_t_hi  = |w_is_t[7:5];

   // Lowest-numbered /T/ is the one that terminates: it is first on the wire.
   always_comb begin
      w_t_lane = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w_is_t[k]) begin
            w_t_lane = 3'(k);
         end
      end
   end

   assign w_below_t = (8'd1 << w_t_lane) - 8'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_bad_nxt   = r_bad;
      w_close     = 1'b0;
      w_close_len = r_len;
      w_close_bad = 1'b0;
      w_proto     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_s0) begin
               if (w_t_any) begin
                  w_close     = 1'b1;
                  w_close_len = {13'd0, w_t_lane} - 16'd1;
                  w_close_bad = 1'b1;
                  w_len_nxt   = 16'd0;
                  w_bad_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_IN_FRAME;
                  w_len_nxt   = 16'd7;
                  w_bad_nxt   = |xge_rxc_i[7:1];
               end
            end else if (w_s4) begin
               // A /T/ ahead of the /S/ is still outside any frame.
               w_proto = w_t_lo;
               if (w_t_hi && !w_t_lo) begin
                  w_close     = 1'b1;
                  w_close_len = {13'd0, w_t_lane} - 16'd5;
                  w_close_bad = 1'b1;
                  w_len_nxt   = 16'd0;
                  w_bad_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_IN_FRAME;
                  w_len_nxt   = 16'd3;
                  w_bad_nxt   = |xge_rxc_i[7:5];
               end
            end else if (w_t_any) begin
               w_proto = 1'b1;
            end
         end
         ST_IN_FRAME: begin
            if (w_s0) begin
               w_close     = 1'b1;
               w_close_len = r_len;
               w_close_bad = 1'b1;
               w_len_nxt   = 16'd7;
               w_bad_nxt   = |xge_rxc_i[7:1];
            end else if (w_s4 && !w_t_lo) begin
               // Restart mid-word: lanes 0..3 still belong to the old frame.
               w_close     = 1'b1;
               w_close_len = sat_add(r_len, 4'd4);
               w_close_bad = 1'b1;
               w_len_nxt   = 16'd3;
               w_bad_nxt   = |xge_rxc_i[7:5];
            end else if (w_t_any) begin
               w_close     = 1'b1;
               w_close_len = sat_add(r_len, {1'b0, w_t_lane});
               w_close_bad = r_bad | (|(xge_rxc_i & w_below_t));
               if (w_s4) begin
                  w_len_nxt = 16'd3;
                  w_bad_nxt = |xge_rxc_i[7:5];
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_len_nxt   = 16'd0;
                  w_bad_nxt   = 1'b0;
               end
            end else begin
               w_len_nxt = sat_add(r_len, 4'd8);
               w_bad_nxt = r_bad | (|xge_rxc_i);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_len_nxt   = 16'd0;
            w_bad_nxt   = 1'b0;
         end
      endcase
   end

   assign w_good = !w_close_bad && (w_close_len >= C_MIN) && (w_close_len <= C_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len           <= 16'd0;
         r_bad           <= 1'b0;
         frame_done_o    <= 1'b0;
         frame_good_o    <= 1'b0;
         last_len_o      <= 16'd0;
         good_cnt_o      <= 32'd0;
         bad_cnt_o       <= 32'd0;
         proto_err_cnt_o <= 16'd0;
      end else begin
         r_len        <= w_len_nxt;
         r_bad        <= w_bad_nxt;
         frame_done_o <= w_close;
         frame_good_o <= w_close & w_good;
         // Clear wins over a same-cycle close; the pulse above still fires.
         if (clr_i) begin
            last_len_o      <= 16'd0;
            good_cnt_o      <= 32'd0;
            bad_cnt_o       <= 32'd0;
            proto_err_cnt_o <= 16'd0;
         end else begin
            if (w_close) begin
               last_len_o <= w_close_len;
               if (w_good) begin
                  good_cnt_o <= good_cnt_o + 32'd1;
               end else begin
                  bad_cnt_o <= bad_cnt_o + 32'd1;
               end
            end
            if (w_proto && (proto_err_cnt_o != C_SAT)) begin
               proto_err_cnt_o <= proto_err_cnt_o + 16'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/xgmii_frame_monitor.md
# xgmii_frame_monitor

Passive XGMII receive-side checker for the PTPv2 testbench, placed directly downstream of the channel delay line. It consumes the delayed 64-bit XGMII stream before or alongside the receiving PTP node and delimits frames on /S/ and /T/. It measures each frame's length, classifies it as good or bad, and keeps running counters that the bench reads to confirm link integrity.

## Interface
- MIN_LEN, 71: minimum legal byte count between /S/ and /T/, both exclusive (7 preamble/SFD + 64).
- MAX_LEN, 1525: maximum legal byte count (7 + 1518).
- clk  input  1  XGMII clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clr_i  input  1  synchronous clear of all counters and the `last_*` outputs; state machine unaffected.
- xge_rxd_i  input  64  XGMII data; lane k = bits [8k+7:8k], lane 0 first on the wire.
- xge_rxc_i  input  8  XGMII control; bit k qualifies lane k.
- frame_done_o  output  1  one-cycle pulse when a frame closes.
- frame_good_o  output  1  classification of the closing frame; valid with frame_done_o.
- last_len_o  output  16  byte count of the most recently closed frame.
- good_cnt_o  output  32  good frames since reset/clear.
- bad_cnt_o  output  32  bad frames since reset/clear.
- proto_err_cnt_o  output  16  /T/ seen outside a frame.

## Operation
- Control characters: /S/ = 0xFB, /T/ = 0xFD, /I/ = 0x07, /E/ = 0xFE.
- /S/ is recognised only in lane 0 or lane 4. /S/ in any other lane is a control error.
- States:
  - IDLE → IN_FRAME on /S/.
  - IN_FRAME → IDLE on /T/.
- Byte accumulation (len, 16 bits, saturating at 0xFFFF):
  - Start word: 7 bytes if /S/ is in lane 0, 3 bytes if in lane 4.
  - Data word with no control bits set: +8.
  - Word with /T/ in lane k: +k, then the frame closes.
- Any control character other than /T/ inside a frame sets bad_flag. The frame continues to /T/.
- A frame closes as good iff bad_flag == 0 and MIN_LEN ≤ len ≤ MAX_LEN. Otherwise it closes as bad.
- /S/ while IN_FRAME (no preceding /T/): the current frame closes as bad with the len accumulated so far, and a new frame starts from that /S/ in the same cycle.
- Same word holds /T/ in lane k ≤ 3 and /S/ in lane 4 while IN_FRAME: the old frame closes with +k, the new frame starts with 3, and the state remains IN_FRAME.
- Same word holds /S/ in lane 0 and /T/ in lane k > 0: the frame opens and closes in that word with len = k−1, and closes as bad.
- /T/ while IDLE (and not preceded by /S/ in the same word): proto_err_cnt_o increments (saturating at 0xFFFF). No frame_done_o.
- Counters good_cnt_o and bad_cnt_o wrap at 2^32.
- clr_i takes priority over a same-cycle increment; the closing frame's counter update is lost. frame_done_o/frame_good_o still pulse for that frame.

## Timing
- All outputs are registered.
- frame_done_o, frame_good_o, last_len_o and counter updates appear on the clock edge that samples the word containing the closing /T/ (or the re-starting /S/). They are visible one cycle after that word is on the inputs.
- frame_done_o is high for exactly one cycle per closed frame. Back-to-back closes in consecutive words give consecutive pulses.
- Reset values (rst_n low, asynchronous):
  - state IDLE, len 0, bad_flag 0.
  - All outputs 0.
- Deasserting rst_n mid-frame: the monitor is IDLE. Words up to the next /S/ are ignored except /T/, which counts as a protocol error.
- No back-pressure; the monitor accepts one word per cycle, every cycle.

## Test plan
- Single 64-byte frame: /S/ in lane 0, 8 data words, /T/ in lane 0 → one frame_done_o pulse, frame_good_o=1, last_len_o=71, good_cnt_o=1.
- 1518-byte frame with /S/ in lane 4 → last_len_o=1525, good. Then a 1519-byte frame → last_len_o=1526, bad, bad_cnt_o=1.
- /E/ injected in lane 3 mid-frame of a 100-byte frame → frame_good_o=0, last_len_o=107, bad_cnt_o=1, good_cnt_o unchanged.
- Minimum-IPG back-to-back: /T/ in lane 2 and /S/ in lane 4 in one word, two 64-byte frames → two pulses, both good, good_cnt_o=2, no protocol error.
- Stray /T/ on an idle link, then /S/ twice without /T/ (second frame terminated normally) → proto_err_cnt_o=1, bad_cnt_o=1, good_cnt_o=1.
- rst_n asserted mid-frame then released, then clr_i pulsed in the same cycle as a good frame closes → all outputs 0 after reset. After the clear, good_cnt_o=0 and frame_done_o has still pulsed.
